// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory arbiter slice: default memory geometry,
// the arbiter FSM state encoding and the requester port identifiers.
// -----------------------------------------------------------------------------
package mem_pkg;

  // Default geometry of the 16x8 single-port memory.
  localparam int MEM_ADDR_W = 4;
  localparam int MEM_DATA_W = 8;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Requester identifiers.
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // The port that did not win last time.
  function automatic logic other_port(input logic p);
    return (p == PORT0) ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin pick.
//   req0, req1  : pending requests from port 0 / port 1
//   last_grant  : port that was granted most recently
//   valid       : at least one request is pending
//   grant       : winning port id (PORT0 / PORT1), meaningful when valid
// -----------------------------------------------------------------------------
module rr_arb2
  import mem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic grant
);

  // A lone requester wins outright; a tie goes to the port not served last.
  always_comb begin
    valid = 1'b0;
    grant = PORT0;
    case ({req1, req0})
      2'b01: begin
        valid = 1'b1;
        grant = PORT0;
      end
      2'b10: begin
        valid = 1'b1;
        grant = PORT1;
      end
      2'b11: begin
        valid = 1'b1;
        grant = other_port(last_grant);
      end
      default: begin
        valid = 1'b0;
        grant = PORT0;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-port arbiter and access sequencer in front of a level-sensitive
// single-port memory. Port 0 (CPU) and port 1 (loader/debug) share the memory;
// ties are broken round-robin. Every transaction runs IDLE -> ACCESS (for
// WAIT_CYCLES cycles) -> RESP (one-cycle ack) -> IDLE. Address and write data
// are latched at grant so the memory sees stable values while read/write is
// asserted.
//
// Ports
//   clk, rst                  : clock (rising edge), async active-high reset
//   req0/we0/addr0/wdata0     : port 0 request, direction, address, write data
//   ack0/rdata0               : port 0 completion pulse and held read data
//   req1/we1/addr1/wdata1     : port 1 request, direction, address, write data
//   ack1/rdata1               : port 1 completion pulse and held read data
//   mem_addr/mem_read/
//   mem_write/mem_wdata       : memory address, read, write and data_in
//   mem_rdata                 : memory data_out
//   busy                      : high in any state other than IDLE
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // The counter counts down to zero inside ACCESS; two bits cover 1..4 waits.
  localparam logic [1:0] CNT_LOAD = 2'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              busy_q, busy_d;

  logic              arb_valid;
  logic              arb_grant;

  rr_arb2 u_rr_arb2 (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .valid      (arb_valid),
    .grant      (arb_grant)
  );

  // Next-state logic: arbitration and latching in IDLE, countdown and read
  // capture in ACCESS, unconditional return from RESP.
  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          port_d       = arb_grant;
          last_grant_d = arb_grant;
          cnt_d        = CNT_LOAD;
          state_d      = ST_ACCESS;
          if (arb_grant == PORT1) begin
            we_d    = we1;
            addr_d  = addr1;
            wdata_d = wdata1;
          end else begin
            we_d    = we0;
            addr_d  = addr0;
            wdata_d = wdata0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_RESP;
          // Only reads touch rdata, and only the granted port's copy.
          if (!we_q) begin
            if (port_q == PORT1) begin
              rdata1_d = mem_rdata;
            end else begin
              rdata0_d = mem_rdata;
            end
          end else begin
            rdata0_d = rdata0_q;
          end
        end else begin
          cnt_d   = cnt_q - 2'd1;
          state_d = ST_ACCESS;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next-state registers so the strobes come straight
  // out of flops and never depend on the requester inputs in the same cycle.
  always_comb begin
    mem_read_d  = (state_d == ST_ACCESS) && !we_d;
    mem_write_d = (state_d == ST_ACCESS) && we_d;
    ack0_d      = (state_d == ST_RESP) && (port_d == PORT0);
    ack1_d      = (state_d == ST_RESP) && (port_d == PORT1);
    busy_d      = (state_d != ST_IDLE);
  end

  // FSM, transaction latches, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      port_q       <= PORT0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= 2'd0;
      last_grant_q <= PORT1;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      busy_q       <= busy_d;
    end
  end

  // Address and data go to the memory straight from the grant-time latches.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Four arbiter instances (WAIT_CYCLES = 1..4), each with its own memory model
// preloaded with mem[4]=8'h70 and mem[10]=8'hCC. A transaction-level reference
// model predicts the grant order, the cycle-by-cycle strobes and the read data.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [NI-1:0] rst_v, req0_v, we0_v, req1_v, we1_v;
  logic [NI-1:0] ack0_v, ack1_v, mem_read_v, mem_write_v, busy_v;
  logic [3:0]    addr0_v [NI];
  logic [3:0]    addr1_v [NI];
  logic [3:0]    mem_addr_v [NI];
  logic [7:0]    wdata0_v [NI];
  logic [7:0]    wdata1_v [NI];
  logic [7:0]    rdata0_v [NI];
  logic [7:0]    rdata1_v [NI];
  logic [7:0]    mem_wdata_v [NI];
  logic [7:0]    mem_rdata_v [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    logic [7:0] mem [16];

    // Memory model: preload while in reset, clocked write, asynchronous read.
    always @(posedge clk) begin
      if (rst_v[k]) begin
        for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
        mem[4]  <= 8'h70;
        mem[10] <= 8'hCC;
      end else if (mem_write_v[k]) begin
        mem[mem_addr_v[k]] <= mem_wdata_v[k];
      end
    end
    assign mem_rdata_v[k] = mem[mem_addr_v[k]];

    mem_arbiter #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(k + 1)) u_dut (
      .clk       (clk),
      .rst       (rst_v[k]),
      .req0      (req0_v[k]),
      .we0       (we0_v[k]),
      .addr0     (addr0_v[k]),
      .wdata0    (wdata0_v[k]),
      .ack0      (ack0_v[k]),
      .rdata0    (rdata0_v[k]),
      .req1      (req1_v[k]),
      .we1       (we1_v[k]),
      .addr1     (addr1_v[k]),
      .wdata1    (wdata1_v[k]),
      .ack1      (ack1_v[k]),
      .rdata1    (rdata1_v[k]),
      .mem_addr  (mem_addr_v[k]),
      .mem_read  (mem_read_v[k]),
      .mem_write (mem_write_v[k]),
      .mem_wdata (mem_wdata_v[k]),
      .mem_rdata (mem_rdata_v[k]),
      .busy      (busy_v[k])
    );
  end

  // Reference model state.
  logic [7:0] model_mem [NI][16];
  logic [7:0] exp_rd0 [NI];
  logic [7:0] exp_rd1 [NI];
  bit         model_last [NI];
  int         ack_log [$];
  int         first_ack_n;

  task automatic check_eq(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    for (int i = 0; i < 16; i++) model_mem[k][i] = 8'h00;
    model_mem[k][4]  = 8'h70;
    model_mem[k][10] = 8'hCC;
    exp_rd0[k]    = 8'h00;
    exp_rd1[k]    = 8'h00;
    model_last[k] = 1'b1;
  endtask

  task automatic check_reset_state(input int k);
    check_eq("rst_busy",  int'(busy_v[k]),      0);
    check_eq("rst_ack0",  int'(ack0_v[k]),      0);
    check_eq("rst_ack1",  int'(ack1_v[k]),      0);
    check_eq("rst_rd",    int'(mem_read_v[k]),  0);
    check_eq("rst_wr",    int'(mem_write_v[k]), 0);
    check_eq("rst_rdat0", int'(rdata0_v[k]),    0);
    check_eq("rst_rdat1", int'(rdata1_v[k]),    0);
    check_eq("rst_maddr", int'(mem_addr_v[k]),  0);
    check_eq("rst_mwdat", int'(mem_wdata_v[k]), 0);
  endtask

  // One arbitration round starting from IDLE at a falling edge. Predicts the
  // serve order and a per-cycle timeline: grant g, ACCESS for g..g+W-1, RESP
  // at g+W, second grant W+2 cycles after the first. Ends back in IDLE.
  task automatic run_txn(input int k, input bit r0, input bit r1,
                         input bit w0, input bit w1,
                         input logic [3:0] a0, input logic [3:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1);
    int wc, nsrv, last_n, p;
    int order [2];
    int g [2];
    bit t_we [2];
    logic [3:0] t_addr [2];
    logic [7:0] t_data [2];
    bit e_busy, e_rd, e_wr, e_ack0, e_ack1, in_acc;
    logic [3:0] e_addr;
    logic [7:0] e_wdata;

    wc = k + 1;
    nsrv = 0;
    order[0] = 0;
    order[1] = 0;
    t_we[0] = w0;   t_we[1] = w1;
    t_addr[0] = a0; t_addr[1] = a1;
    t_data[0] = d0; t_data[1] = d1;
    if (r0 && r1) begin
      order[0] = model_last[k] ? 0 : 1;
      order[1] = 1 - order[0];
      nsrv = 2;
    end else if (r0) begin
      order[0] = 0;
      nsrv = 1;
    end else if (r1) begin
      order[0] = 1;
      nsrv = 1;
    end
    if (nsrv > 0) model_last[k] = (order[nsrv-1] == 1);
    g[0] = 1;
    g[1] = wc + 3;
    last_n = (nsrv == 0) ? 2 : g[nsrv-1] + wc + 1;
    first_ack_n = -1;

    req0_v[k] = r0; we0_v[k] = w0; addr0_v[k] = a0; wdata0_v[k] = d0;
    req1_v[k] = r1; we1_v[k] = w1; addr1_v[k] = a1; wdata1_v[k] = d1;

    for (int n = 1; n <= last_n; n++) begin
      @(posedge clk);
      @(negedge clk);
      e_busy = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_ack0 = 1'b0; e_ack1 = 1'b0;
      in_acc = 1'b0; e_addr = 4'h0; e_wdata = 8'h00;
      for (int s = 0; s < nsrv; s++) begin
        p = order[s];
        if (n >= g[s] && n < g[s] + wc) begin
          e_busy = 1'b1; in_acc = 1'b1;
          e_addr = t_addr[p]; e_wdata = t_data[p];
          if (t_we[p]) e_wr = 1'b1; else e_rd = 1'b1;
        end else if (n == g[s] + wc) begin
          e_busy = 1'b1;
          if (p == 0) e_ack0 = 1'b1; else e_ack1 = 1'b1;
          if (t_we[p]) model_mem[k][t_addr[p]] = t_data[p];
          else if (p == 0) exp_rd0[k] = model_mem[k][t_addr[p]];
          else exp_rd1[k] = model_mem[k][t_addr[p]];
        end
      end
      check_eq("busy",   int'(busy_v[k]),      int'(e_busy));
      check_eq("mem_rd", int'(mem_read_v[k]),  int'(e_rd));
      check_eq("mem_wr", int'(mem_write_v[k]), int'(e_wr));
      check_eq("ack0",   int'(ack0_v[k]),      int'(e_ack0));
      check_eq("ack1",   int'(ack1_v[k]),      int'(e_ack1));
      check_eq("rdata0", int'(rdata0_v[k]),    int'(exp_rd0[k]));
      check_eq("rdata1", int'(rdata1_v[k]),    int'(exp_rd1[k]));
      if (in_acc) check_eq("mem_addr", int'(mem_addr_v[k]), int'(e_addr));
      if (e_wr) check_eq("mem_wdata", int'(mem_wdata_v[k]), int'(e_wdata));
      if (ack0_v[k]) ack_log.push_back(0);
      if (ack1_v[k]) ack_log.push_back(1);
      if ((ack0_v[k] || ack1_v[k]) && first_ack_n < 0) first_ack_n = n;
      // Scramble the granted port's address/data during its access, drop
      // its request once acknowledged.
      for (int s = 0; s < nsrv; s++) begin
        p = order[s];
        if (n == g[s]) begin
          if (p == 0) begin
            addr0_v[k] = 4'($urandom_range(0, 15)); wdata0_v[k] = 8'($urandom);
          end else begin
            addr1_v[k] = 4'($urandom_range(0, 15)); wdata1_v[k] = 8'($urandom);
          end
        end
        if (n == g[s] + wc) begin
          if (p == 0) req0_v[k] = 1'b0; else req1_v[k] = 1'b0;
        end
      end
    end
    req0_v[k] = 1'b0;
    req1_v[k] = 1'b0;
  endtask

  task automatic run_random(input int k, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      run_txn(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              8'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    rst_v = 4'hF; req0_v = 4'h0; we0_v = 4'h0; req1_v = 4'h0; we1_v = 4'h0;
    for (int k = 0; k < NI; k++) begin
      addr0_v[k] = 4'h0; addr1_v[k] = 4'h0;
      wdata0_v[k] = 8'h00; wdata1_v[k] = 8'h00;
      model_reset(k);
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) check_reset_state(k);
    rst_v = 4'h0;
    @(negedge clk);

    // Simultaneous first request: port 0 (addr 4) first, then port 1 (addr 10).
    ack_log.delete();
    run_txn(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h4, 4'hA, 8'h00, 8'h00);
    check_eq("first_order_len", ack_log.size(), 2);
    if (ack_log.size() == 2) begin
      check_eq("first_order0", ack_log[0], 0);
      check_eq("first_order1", ack_log[1], 1);
    end
    check_eq("first_rdata0", int'(rdata0_v[0]), 8'h70);
    check_eq("first_rdata1", int'(rdata1_v[0]), 8'hCC);

    // Directed read, write, read-back.
    run_txn(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 4'h0, 8'h00, 8'h00);
    check_eq("lat_w1", first_ack_n, 2);
    run_txn(0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h3, 8'h00, 8'h5A);
    run_txn(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 8'h00, 8'h00);
    check_eq("readback", int'(rdata0_v[0]), 8'h5A);
    run_txn(0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h3, 8'h00, 8'h00);

    // Fairness: both ports requesting for six transactions.
    ack_log.delete();
    for (int i = 0; i < 3; i++) begin
      run_txn(0, 1'b1, 1'b1, 1'b0, 1'b0,
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 8'h00, 8'h00);
    end
    check_eq("fair_len", ack_log.size(), 6);
    for (int i = 0; i < ack_log.size(); i++) check_eq("fair_order", ack_log[i], i % 2);

    run_random(0, 30);

    // Latency sweep on the other wait settings.
    for (int k = 1; k < NI; k++) begin
      run_txn(k, 1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 4'h0, 8'h00, 8'h00);
      check_eq("lat_sweep", first_ack_n, k + 2);
      check_eq("lat_rdata", int'(rdata0_v[k]), 8'hCC);
    end

    // Reset in the second ACCESS cycle of a port 0 write (WAIT_CYCLES = 3).
    run_txn(2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, 4'h0, 8'h00, 8'h00);
    req0_v[2] = 1'b1; we0_v[2] = 1'b1; addr0_v[2] = 4'h6; wdata0_v[2] = 8'h3C;
    @(posedge clk); @(negedge clk);
    check_eq("mw_wr_before", int'(mem_write_v[2]), 1);
    @(posedge clk); @(negedge clk);
    check_eq("mw_wr_second", int'(mem_write_v[2]), 1);
    rst_v[2] = 1'b1;
    req0_v[2] = 1'b0; we0_v[2] = 1'b0;
    #1;
    check_eq("mw_wr_drop", int'(mem_write_v[2]), 0);
    check_eq("mw_busy",    int'(busy_v[2]),      0);
    check_eq("mw_ack0",    int'(ack0_v[2]),      0);
    check_eq("mw_rdata0",  int'(rdata0_v[2]),    0);
    @(negedge clk);
    rst_v[2] = 1'b0;
    model_reset(2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("mw_no_ack", int'(ack0_v[2]), 0);
    end
    run_txn(2, 1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 4'h0, 8'h00, 8'h00);
    check_eq("mw_after", int'(rdata0_v[2]), 8'hCC);

    for (int k = 1; k < NI; k++) run_random(k, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and access sequencer in front of the 16x8 single-port memory module.
- Shares the memory between requester 0 (CPU fetch/execute unit) and requester 1 (loader/debug port).
- Drives the memory's address, read, write and data_in; captures its data_out.
- Owns all access timing: the memory's level-sensitive read/write is only ever asserted with stable address and data.

Parameters:
- ADDR_W, 4, memory address width (16 words).
- DATA_W, 8, memory word width.
- WAIT_CYCLES, 1, cycles spent in ACCESS per transaction; legal range 1..4.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0  input  1  port 0 request; held high until ack0.
- we0  input  1  port 0: 1 = write, 0 = read; stable while req0 is high.
- addr0  input  ADDR_W  port 0 address.
- wdata0  input  DATA_W  port 0 write data.
- ack0  output  1  one-cycle completion pulse for port 0.
- rdata0  output  DATA_W  port 0 read data; valid with ack0, then held.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- mem_addr  output  ADDR_W  to memory address.
- mem_read  output  1  to memory read.
- mem_write  output  1  to memory write.
- mem_wdata  output  DATA_W  to memory data_in.
- mem_rdata  input  DATA_W  from memory data_out.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values (rst high, asynchronous): state = IDLE, ack0/ack1 = 0, rdata0/rdata1 = 0, mem_read/mem_write = 0, mem_addr/mem_wdata = 0, busy = 0, last_grant = 1 (so port 0 wins first), wait counter = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req high: grant that port.
  - Both req high: grant the port that is not last_grant.
  - On grant: latch port id, we, addr and wdata into internal registers; load the counter with WAIT_CYCLES-1; go to ACCESS; update last_grant.
- ACCESS:
  - mem_addr and mem_wdata come from the latched registers (stable for the whole phase).
  - mem_read = ~we_latched; mem_write = we_latched.
  - The counter decrements each cycle.
  - In the cycle where the counter is 0: if the access is a read, capture mem_rdata into rdata of the granted port at the clock edge; go to RESP.
- RESP:
  - mem_read = mem_write = 0.
  - ack of the granted port = 1 for exactly this cycle.
  - Unconditionally go to IDLE; no arbitration in RESP.
- Decoding: mem_read, mem_write and ack are decoded from state registers only, never from inputs.
- Latency: the req sampled in IDLE at edge T. Cycles T+1..T+WAIT_CYCLES are ACCESS, cycle T+WAIT_CYCLES+1 is RESP (ack). With the default, ack comes 2 cycles after the grant edge. Throughput is one access per WAIT_CYCLES+2 cycles.
- Requester rule: deassert req (or present a new request) at the edge ending the ack cycle. A req still high in IDLE is a new request.
- Writes leave rdata of both ports unchanged. rdata of the non-granted port never changes.
- Inputs that change after grant have no effect on the running access.
- req dropped before grant: ignored, with no side effects.
- All 16 addresses are valid; there is no wrap or out-of-range handling.
- Reset mid-ACCESS: mem_write/mem_read fall immediately (asynchronous), no ack is issued, rdata is cleared, state returns to IDLE. The interrupted write's memory contents are undefined.
- Round-robin fairness: with both ports continuously requesting, grants alternate 0,1,0,1,...

Decomposition:
- Shared package mem_pkg:
  - ADDR_W and DATA_W defaults.
  - State encoding constants ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESP = 2'd2.
  - Port id constants PORT0 = 1'b0, PORT1 = 1'b1.
- One natural sub-module: rr_arb2, a combinational 2-way round-robin pick from req0, req1 and last_grant.
- The FSM, latches and counter stay in mem_arbiter.

Test Plan (bench instantiates mem_arbiter plus the memory model preloaded with mem[4]=8'h70, mem[10]=8'hCC):
- Read: port 0 read, addr0=4'hA -> busy 1 cycle after the grant edge; mem_read high 1 cycle; ack0 pulse 2 cycles after grant; rdata0 = 8'hCC; ack1 stays 0.
- Write then read: port 1 write, addr1=4'h3, wdata1=8'h5A -> mem_write high exactly 1 cycle with mem_addr=3, ack1 pulse. Then port 0 read of addr 3 -> rdata0 = 8'h5A, rdata1 unchanged.
- Simultaneous first request after reset: req0 and req1 both high, port 0 reads addr 4, port 1 reads addr 10 -> port 0 served first (rdata0 = 8'h70), then port 1 (rdata1 = 8'hCC). Acks are 3 cycles apart.
- Fairness: both reqs held high for 6 transactions -> ack order 0,1,0,1,0,1; no cycle has ack0 and ack1 both high.
- Reset mid-write: port 0 write in progress with WAIT_CYCLES=3; rst pulsed in the second ACCESS cycle -> mem_write drops in the same cycle, busy = 0, no ack0, rdata0 = 0. The next request is served normally.
- Latency sweep: with WAIT_CYCLES = 1, 2, 4, the gap from grant edge to ack is 2, 3 and 5 cycles; mem_read stays high for exactly WAIT_CYCLES cycles.
